// File: rtl/mips_dmem_pkg.sv
// Shared constants for the MIPS data-memory responder: MMIO register offsets,
// status-word layout and drop-counter width.
package mips_dmem_pkg;

   localparam logic [3:0] OFF_TX_DATA   = 4'h0;
   localparam logic [3:0] OFF_TX_STATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLE     = 4'h8;
   localparam logic [3:0] OFF_DROPS     = 4'hC;

   localparam logic [3:0] OFF_REG_MASK  = 4'hC;
   localparam logic [31:0] MMIO_PAGE_BYTES = 32'd16;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_COUNT_LSB = 8;

   localparam int DROP_WIDTH = 16;

   // TX_STATUS word: empty/full flags plus zero-extended occupancy.
   function automatic logic [31:0] tx_status_word(input logic empty,
                                                  input logic full,
                                                  input logic [7:0] count);
      logic [31:0] w;
      w = 32'h0000_0000;
      w[STAT_EMPTY] = empty;
      w[STAT_FULL]  = full;
      w[STAT_COUNT_LSB +: 8] = count;
      return w;
   endfunction

endpackage

// File: rtl/mips_tx_fifo.sv
// Synchronous FIFO for the console TX path. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module mips_tx_fifo
   import mips_dmem_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [0:DEPTH-1];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign count     = count_r;
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;

   // Head presentation; zero while empty.
   always_comb begin
      head = {WIDTH{1'b0}};
      if (!empty) begin
         head = mem_r[rd_ptr_r];
      end else begin
         head = {WIDTH{1'b0}};
      end
   end

   // Storage write; when full with a pop, wr_ptr equals rd_ptr and the freed slot is reused.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: byte-lane RAM with registered read,
// plus an MMIO page with console TX FIFO, cycle counter and drop counter.
module mips_dmem_responder
   import mips_dmem_pkg::*;
#(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int          TX_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] mem_addr,
   input  logic        mem_read_en,
   input  logic [3:0]  mem_write_en,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int CNT_W = $clog2(TX_DEPTH) + 1;

   logic [31:0]           ram_r [0:(2**ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] word_idx_s;
   logic                  is_mmio_s;
   logic [31:0]           mmio_off_s;
   logic                  mmio_hit_s;
   logic [3:0]            reg_sel_s;
   logic                  ram_we_s;
   logic                  push_s;
   logic                  cycle_load_s;
   logic                  drops_clr_s;
   logic                  pop_s;
   logic                  drop_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic [CNT_W-1:0]      fifo_count_s;
   logic [7:0]            fifo_head_s;
   logic [31:0]           rd_word_s;
   logic [31:0]           cycle_r;
   logic [DROP_WIDTH-1:0] drops_r;

   assign word_idx_s = mem_addr[ADDR_WIDTH+1:2];
   assign is_mmio_s  = (mem_addr >= MMIO_BASE);
   assign mmio_off_s = mem_addr - MMIO_BASE;
   assign mmio_hit_s = is_mmio_s && (mmio_off_s < MMIO_PAGE_BYTES);
   assign reg_sel_s  = mmio_off_s[3:0] & OFF_REG_MASK;
   assign ram_we_s   = en && !rst && !is_mmio_s;
   assign pop_s      = !fifo_empty_s && tx_ready;
   assign drop_s     = push_s && fifo_full_s && !pop_s;
   assign tx_valid   = !fifo_empty_s;
   assign tx_data    = fifo_head_s;

   // MMIO write decode.
   always_comb begin
      push_s       = 1'b0;
      cycle_load_s = 1'b0;
      drops_clr_s  = 1'b0;
      if (en && mmio_hit_s) begin
         case (reg_sel_s)
            OFF_TX_DATA: push_s       = mem_write_en[0];
            OFF_CYCLE:   cycle_load_s = (mem_write_en == 4'hF);
            OFF_DROPS:   drops_clr_s  = (mem_write_en != 4'h0);
            default:     push_s       = 1'b0;
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Read mux over RAM and MMIO registers (pre-update values).
   always_comb begin
      rd_word_s = 32'h0000_0000;
      if (!is_mmio_s) begin
         rd_word_s = ram_r[word_idx_s];
      end else if (mmio_hit_s) begin
         case (reg_sel_s)
            OFF_TX_STATUS: rd_word_s = tx_status_word(fifo_empty_s, fifo_full_s,
                                                      8'(fifo_count_s));
            OFF_CYCLE:     rd_word_s = cycle_r;
            OFF_DROPS:     rd_word_s = {{(32-DROP_WIDTH){1'b0}}, drops_r};
            default:       rd_word_s = 32'h0000_0000;
         endcase
      end else begin
         rd_word_s = 32'h0000_0000;
      end
   end

   // RAM byte-lane writes; contents survive reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ram_we_s && mem_write_en[k]) begin
            ram_r[word_idx_s][8*k +: 8] <= mem_write_data[8*k +: 8];
         end
      end
   end

   // Registered read data, held when no read is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read_data <= 32'h0000_0000;
      end else if (en && mem_read_en) begin
         mem_read_data <= rd_word_s;
      end
   end

   // Free-running cycle counter; a software load beats the increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_r <= 32'h0000_0000;
      end else if (en) begin
         cycle_r <= cycle_load_s ? mem_write_data : cycle_r + 32'd1;
      end
   end

   // Saturating count of pushes rejected by a full FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         drops_r <= {DROP_WIDTH{1'b0}};
      end else if (drops_clr_s) begin
         drops_r <= {DROP_WIDTH{1'b0}};
      end else if (drop_s && (drops_r != {DROP_WIDTH{1'b1}})) begin
         drops_r <= drops_r + {{(DROP_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   mips_tx_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (mem_write_data[7:0]),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

endmodule
